// File: rtl/riscv_test_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : riscv_test_pkg
//  Purpose  : Shared types and constants for the riscv-tests end-of-test
//             monitor: FSM state encoding, default watched register indices
//             and the pass/flag magic value.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package riscv_test_pkg;

   typedef enum logic [1:0] {
      ST_RUN    = 2'd0,
      ST_SETTLE = 2'd1,
      ST_DONE   = 2'd2
   } state_t;

   // riscv-tests convention: gp = test number, s10 = done flag, s11 = result
   localparam int unsigned DEF_TNUM_REG   = 3;
   localparam int unsigned DEF_FLAG_REG   = 26;
   localparam int unsigned DEF_RESULT_REG = 27;

   localparam logic [31:0] PASS_VALUE = 32'h1;
   localparam logic [31:0] FLAG_VALUE = 32'h1;

endpackage
`default_nettype wire

// File: rtl/riscv_test_monitor_if.sv
`default_nettype none
// ============================================================================
//  Module   : riscv_test_monitor_if
//  Purpose  : Register-file writeback tap observed by the test monitor.
//  Ports    : wb_en   - writeback enable
//             wb_addr - destination register index (5 bits)
//             wb_data - write data (32 bits)
//             modport master drives the bus, modport slave observes it.
//  Revision : 1.0 - initial release
// ============================================================================
interface riscv_test_monitor_if;
   logic        wb_en;
   logic [4:0]  wb_addr;
   logic [31:0] wb_data;

   modport master (output wb_en, output wb_addr, output wb_data);
   modport slave  (input  wb_en, input  wb_addr, input  wb_data);
endinterface
`default_nettype wire

// File: rtl/riscv_test_monitor.sv
`default_nettype none
// ============================================================================
//  Module   : riscv_test_monitor
//  Purpose  : Shadows the test-number, done-flag and result registers from
//             the CPU writeback port. After the flag is written with 1 it waits
//             a settle window and latches a pass/fail verdict; an optional
//             run-cycle timeout forces a failing verdict.
//  Ports    : clk        - system clock, rising edge
//             rst        - synchronous active-high reset
//             wb         - writeback tap (slave modport)
//             done       - verdict valid (level)
//             done_pulse - one-cycle strobe when done first rises
//             pass/fail  - verdict
//             timeout    - verdict forced by timeout
//             test_num   - test-number shadow captured at the verdict
//             run_cycles - saturating count of cycles spent in RUN
//  Revision : 1.0 - initial release
// ============================================================================
module riscv_test_monitor
   import riscv_test_pkg::*;
#(
   parameter int unsigned SETTLE_CYCLES  = 10,
   parameter int unsigned TIMEOUT_CYCLES = 100000,
   parameter int unsigned TNUM_REG       = DEF_TNUM_REG,
   parameter int unsigned FLAG_REG       = DEF_FLAG_REG,
   parameter int unsigned RESULT_REG     = DEF_RESULT_REG
) (
   input  logic                  clk,
   input  logic                  rst,
   riscv_test_monitor_if.slave   wb,
   output logic                  done,
   output logic                  done_pulse,
   output logic                  pass,
   output logic                  fail,
   output logic                  timeout,
   output logic [31:0]           test_num,
   output logic [31:0]           run_cycles
);

   // A zero-length window would never match the counter, so it degrades to 1.
   localparam int unsigned SETTLE_EFF  = (SETTLE_CYCLES == 0) ? 1 : SETTLE_CYCLES;
   localparam logic [31:0] SETTLE_LAST = 32'(SETTLE_EFF - 1);
   localparam logic [31:0] TIMEOUT_LIM = 32'(TIMEOUT_CYCLES);
   localparam bit          TIMEOUT_EN  = (TIMEOUT_CYCLES != 0);
   localparam logic [4:0]  TNUM_IDX    = 5'(TNUM_REG);
   localparam logic [4:0]  FLAG_IDX    = 5'(FLAG_REG);
   localparam logic [4:0]  RESULT_IDX  = 5'(RESULT_REG);

   state_t      state, state_nxt;
   logic [31:0] tnum_sh, tnum_nxt;
   logic [31:0] flag_sh, flag_nxt;
   logic [31:0] result_sh, result_nxt;
   logic [31:0] settle_cnt, settle_nxt;
   logic [31:0] run_nxt, run_inc;
   logic        done_nxt, pulse_nxt, pass_nxt, fail_nxt, timeout_nxt;
   logic [31:0] test_num_nxt;
   logic        wr_valid, flag_wr, flag_hit, timeout_hit;

   assign run_inc     = (run_cycles == 32'hFFFF_FFFF) ? run_cycles : run_cycles + 32'd1;
   // x0 is hard-wired to zero in the core, so writes to it never count.
   assign wr_valid    = wb.wb_en && (wb.wb_addr != 5'd0);
   assign flag_wr     = wr_valid && (wb.wb_addr == FLAG_IDX);
   assign timeout_hit = TIMEOUT_EN && (run_inc == TIMEOUT_LIM);

   always_comb begin
      state_nxt    = state;
      tnum_nxt     = tnum_sh;
      flag_nxt     = flag_sh;
      result_nxt   = result_sh;
      settle_nxt   = settle_cnt;
      run_nxt      = run_cycles;
      done_nxt     = done;
      pulse_nxt    = 1'b0;
      pass_nxt     = pass;
      fail_nxt     = fail;
      timeout_nxt  = timeout;
      test_num_nxt = test_num;

      if (state != ST_DONE && wr_valid) begin
         if (wb.wb_addr == TNUM_IDX)   tnum_nxt   = wb.wb_data;
         if (wb.wb_addr == FLAG_IDX)   flag_nxt   = wb.wb_data;
         if (wb.wb_addr == RESULT_IDX) result_nxt = wb.wb_data;
      end

      // Only an actual write of the magic value triggers, not a stale shadow.
      flag_hit = flag_wr && (flag_nxt == FLAG_VALUE);

      case (state)
         ST_RUN: begin
            run_nxt = run_inc;
            if (flag_hit) begin
               state_nxt  = ST_SETTLE;
               settle_nxt = 32'd0;
            end else if (timeout_hit) begin
               state_nxt    = ST_DONE;
               done_nxt     = 1'b1;
               pulse_nxt    = 1'b1;
               pass_nxt     = 1'b0;
               fail_nxt     = 1'b1;
               timeout_nxt  = 1'b1;
               test_num_nxt = tnum_nxt;
            end
         end
         ST_SETTLE: begin
            settle_nxt = settle_cnt + 32'd1;
            if (settle_cnt == SETTLE_LAST) begin
               // Next-state shadows so a write on the final cycle is honoured.
               state_nxt    = ST_DONE;
               done_nxt     = 1'b1;
               pulse_nxt    = 1'b1;
               pass_nxt     = (result_nxt == PASS_VALUE);
               fail_nxt     = (result_nxt != PASS_VALUE);
               test_num_nxt = tnum_nxt;
            end
         end
         default: begin
            state_nxt = ST_DONE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= ST_RUN;
         tnum_sh    <= 32'd0;
         flag_sh    <= 32'd0;
         result_sh  <= 32'd0;
         settle_cnt <= 32'd0;
         run_cycles <= 32'd0;
         done       <= 1'b0;
         done_pulse <= 1'b0;
         pass       <= 1'b0;
         fail       <= 1'b0;
         timeout    <= 1'b0;
         test_num   <= 32'd0;
      end else begin
         state      <= state_nxt;
         tnum_sh    <= tnum_nxt;
         flag_sh    <= flag_nxt;
         result_sh  <= result_nxt;
         settle_cnt <= settle_nxt;
         run_cycles <= run_nxt;
         done       <= done_nxt;
         done_pulse <= pulse_nxt;
         pass       <= pass_nxt;
         fail       <= fail_nxt;
         timeout    <= timeout_nxt;
         test_num   <= test_num_nxt;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_riscv_test_monitor.sv
`default_nettype none
// ============================================================================
//  Module   : tb_riscv_test_monitor
//  Purpose  : Directed self-checking bench for riscv_test_monitor
//             (SETTLE_CYCLES=10, TIMEOUT_CYCLES=50).
//  Ports    : none
//  Revision : 1.0 - initial release
// ============================================================================
module tb_riscv_test_monitor;

   logic        clk = 1'b0;
   logic        rst;
   logic        done, done_pulse, pass, fail, timeout;
   logic [31:0] test_num, run_cycles;
   int          ntests = 0;
   int          nfail  = 0;

   riscv_test_monitor_if bus();

   riscv_test_monitor #(
      .SETTLE_CYCLES  (10),
      .TIMEOUT_CYCLES (50),
      .TNUM_REG       (3),
      .FLAG_REG       (26),
      .RESULT_REG     (27)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .wb         (bus),
      .done       (done),
      .done_pulse (done_pulse),
      .pass       (pass),
      .fail       (fail),
      .timeout    (timeout),
      .test_num   (test_num),
      .run_cycles (run_cycles)
   );

   always #5 clk = ~clk;

   // Advance one edge; inputs change and outputs are sampled 1 time unit later.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic wr(input logic [4:0] addr, input logic [31:0] data);
      bus.wb_en   = 1'b1;
      bus.wb_addr = addr;
      bus.wb_data = data;
      tick();
      bus.wb_en   = 1'b0;
      bus.wb_addr = 5'd0;
      bus.wb_data = 32'd0;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      ntests++;
      assert (obs === exp) else begin
         nfail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic chk_verdict(input string tag, input logic d, input logic dp, input logic p,
                              input logic f, input logic t, input logic [31:0] tn);
      chk({tag, ".done"},       {31'd0, done},       {31'd0, d});
      chk({tag, ".done_pulse"}, {31'd0, done_pulse}, {31'd0, dp});
      chk({tag, ".pass"},       {31'd0, pass},       {31'd0, p});
      chk({tag, ".fail"},       {31'd0, fail},       {31'd0, f});
      chk({tag, ".timeout"},    {31'd0, timeout},    {31'd0, t});
      chk({tag, ".test_num"},   test_num,            tn);
   endtask

   task automatic do_reset();
      rst         = 1'b1;
      bus.wb_en   = 1'b0;
      bus.wb_addr = 5'd0;
      bus.wb_data = 32'd0;
      ticks(2);
      rst = 1'b0;
   endtask

   initial begin
      // Reset state
      do_reset();
      rst = 1'b1;
      tick();
      chk_verdict("reset", 0, 0, 0, 0, 0, 32'd0);
      chk("reset.run_cycles", run_cycles, 32'd0);
      rst = 1'b0;

      // Pass path: done exactly 10 edges after the flag edge
      wr(5'd3, 32'd5);
      wr(5'd27, 32'd1);
      wr(5'd26, 32'd1);
      ticks(9);
      chk("pass.early", {31'd0, done}, 32'd0);
      tick();
      chk_verdict("pass", 1, 1, 1, 0, 0, 32'd5);
      chk("pass.run_cycles", run_cycles, 32'd3);
      tick();
      chk("pass.pulse_width", {31'd0, done_pulse}, 32'd0);
      chk("pass.hold", {31'd0, done}, 32'd1);

      // Fail path
      do_reset();
      wr(5'd3, 32'd7);
      wr(5'd26, 32'd1);
      wr(5'd27, 32'd0);
      ticks(9);
      chk_verdict("fail", 1, 1, 0, 1, 0, 32'd7);

      // Late test-number write inside the settle window
      do_reset();
      wr(5'd3, 32'd7);
      wr(5'd26, 32'd1);
      ticks(5);
      wr(5'd3, 32'd9);
      ticks(4);
      chk_verdict("late_tnum", 1, 1, 0, 1, 0, 32'd9);

      // Result written on the final settle edge still counts
      do_reset();
      wr(5'd26, 32'd1);
      ticks(9);
      wr(5'd27, 32'd1);
      chk_verdict("last_cycle", 1, 1, 1, 0, 0, 32'd0);

      // Same write one cycle after done changes nothing
      do_reset();
      wr(5'd3, 32'd4);
      wr(5'd26, 32'd1);
      ticks(10);
      chk_verdict("after_done.verdict", 1, 1, 0, 1, 0, 32'd4);
      wr(5'd27, 32'd1);
      wr(5'd3, 32'd11);
      chk_verdict("after_done.frozen", 1, 0, 0, 1, 0, 32'd4);
      chk("after_done.run_cycles", run_cycles, 32'd2);

      // Non-unit flag and x0 writes keep the monitor in RUN
      do_reset();
      wr(5'd26, 32'd2);
      wr(5'd0, 32'd1);
      ticks(15);
      chk("nonunit.done", {31'd0, done}, 32'd0);
      chk("nonunit.run_cycles", run_cycles, 32'd17);
      wr(5'd27, 32'd1);
      wr(5'd26, 32'd1);
      ticks(9);
      chk("nonunit.early", {31'd0, done}, 32'd0);
      tick();
      chk_verdict("nonunit", 1, 1, 1, 0, 0, 32'd0);

      // Timeout after 50 run cycles
      do_reset();
      ticks(49);
      chk("timeout.before", {31'd0, done}, 32'd0);
      chk("timeout.run49", run_cycles, 32'd49);
      tick();
      chk_verdict("timeout", 1, 1, 0, 1, 1, 32'd0);
      chk("timeout.run50", run_cycles, 32'd50);
      tick();
      chk("timeout.pulse_width", {31'd0, done_pulse}, 32'd0);
      chk("timeout.run_hold", run_cycles, 32'd50);

      // Flag on the expiry edge wins over the timeout
      do_reset();
      ticks(49);
      wr(5'd26, 32'd1);
      chk("flag_wins.done", {31'd0, done}, 32'd0);
      chk("flag_wins.run50", run_cycles, 32'd50);
      ticks(9);
      chk("flag_wins.early", {31'd0, done}, 32'd0);
      tick();
      chk_verdict("flag_wins", 1, 1, 0, 1, 0, 32'd0);
      chk("flag_wins.run_frozen", run_cycles, 32'd50);

      // Reset in the middle of the settle window
      do_reset();
      wr(5'd3, 32'd5);
      wr(5'd27, 32'd1);
      wr(5'd26, 32'd1);
      ticks(4);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk_verdict("mid_reset", 0, 0, 0, 0, 0, 32'd0);
      chk("mid_reset.run_cycles", run_cycles, 32'd0);
      ticks(8);
      chk("mid_reset.no_verdict", {31'd0, done}, 32'd0);
      // Shadows were cleared: a bare flag now yields fail with test_num 0
      wr(5'd26, 32'd1);
      ticks(10);
      chk_verdict("mid_reset.cleared", 1, 1, 0, 1, 0, 32'd0);
      do_reset();
      wr(5'd3, 32'd6);
      wr(5'd27, 32'd1);
      wr(5'd26, 32'd1);
      ticks(10);
      chk_verdict("mid_reset.rerun", 1, 1, 1, 0, 0, 32'd6);

      $display("[TB] %0d tests run, %0d failed", ntests, nfail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/riscv_test_monitor.md
# riscv_test_monitor

Synthesizable end-of-test detector that sits downstream of the CPU core's register-file writeback port in `cpu_top_soc`. It shadows the riscv-tests convention registers: x3 holds the test number, x26 is the done flag, and x27 is the result. Once x26 is written with 1, it waits a settle window and then latches a pass/fail verdict. It replaces hierarchical register peeking in simulation and drives LEDs/UART status on FPGA.

## Interface
Parameters:
- `SETTLE_CYCLES`, 10: cycles between the flag write and the verdict (200 ns at 20 ns clk).
- `TIMEOUT_CYCLES`, 100000: run cycles before a forced fail; 0 disables the timeout.
- `TNUM_REG`, 3: test-number register index.
- `FLAG_REG`, 26: done-flag register index.
- `RESULT_REG`, 27: result register index.

Ports:
- `clk`  in  1  system clock; all logic on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `wb_en`  in  1  register-file write enable, taken from the CPU writeback stage.
- `wb_addr`  in  5  destination register index.
- `wb_data`  in  32  write data.
- `done`  out  1  level; set once a verdict exists.
- `done_pulse`  out  1  one-cycle strobe on the first cycle `done`=1.
- `pass`  out  1  verdict: the result register equalled 1.
- `fail`  out  1  verdict: not pass, or timeout.
- `timeout`  out  1  the verdict was forced by timeout.
- `test_num`  out  32  value of the test-number register at the verdict.
- `run_cycles`  out  32  cycles spent in RUN, saturating at 0xFFFF_FFFF.

## Operation
- States:
  - RUN: waiting for the flag.
  - SETTLE: window after the flag.
  - DONE: verdict held.
- Reset:
  - State goes to RUN.
  - All outputs are 0.
  - The shadows of x3, x26 and x27 are 0.
  - The settle counter and `run_cycles` are 0.
- Shadow update:
  - Applies in RUN and SETTLE.
  - When `wb_en` and `wb_addr` equals a watched index, the matching shadow takes `wb_data`.
  - `wb_addr`=0 is always ignored.
  - Shadows are frozen in DONE.
- Transitions out of RUN:
  - A write of exactly 32'h1 to FLAG_REG moves to SETTLE and clears the settle counter.
  - A flag write with any other value only updates the shadow.
  - If `run_cycles`+1 reaches TIMEOUT_CYCLES (nonzero) with no flag write, move to DONE with `timeout`=1, `fail`=1, `pass`=0.
  - A flag write and timeout expiry in the same cycle: the flag wins.
- `run_cycles` increments every cycle in RUN. It stops in SETTLE and DONE.
- SETTLE:
  - The counter increments each cycle.
  - On the cycle the counter equals SETTLE_CYCLES-1, move to DONE.
  - `pass` is evaluated from the next-state x27 shadow, so a write of x27 in that same cycle counts.
  - `test_num` takes the next-state x3 shadow.
  - `fail`=~`pass`.
  - SETTLE_CYCLES=0 is treated as 1.
- DONE:
  - Absorbing; only `rst` leaves it.
  - Writeback writes are ignored.
- Reset mid-operation (any state) returns to the reset values on the next edge. No partial verdict survives.

## Timing
- Flag write sampled at edge N puts the block in SETTLE from N.
- `done` and `done_pulse` go high after edge N+SETTLE_CYCLES.
- `done_pulse` is high for exactly one cycle. `pass`, `fail`, `timeout` and `test_num` are valid in the same cycle as `done`.
- Timeout: `done` goes high on the edge where `run_cycles` would reach TIMEOUT_CYCLES. At that point `run_cycles` reads TIMEOUT_CYCLES.
- All outputs are registered; there are no combinational paths from `wb_*` to outputs.

## Structure
- Package `riscv_test_pkg` holds:
  - the state enum (RUN, SETTLE, DONE);
  - default register index constants;
  - the `PASS_VALUE`/`FLAG_VALUE` constant (32'h1).
- A single module with no sub-modules; the saturating counters are inline.
- Instantiated in `cpu_top_soc` on the same `clk`/`rst` as the CPU, tapping the writeback bus in parallel with the register file.

## Test plan
- Pass path: write x3=5, x27=1, then x26=1 → `done` exactly 10 cycles after the flag edge, with `pass`=1, `fail`=0, `test_num`=5, `done_pulse` width 1.
- Fail path: write x3=7, x26=1, x27=0 → `fail`=1, `test_num`=7; also check that a late write of x3=9 during SETTLE updates `test_num` to 9.
- Last-cycle write: x27=1 written on the final SETTLE cycle → `pass`=1; the same write one cycle after `done` → no change in any output.
- Non-unit flag / x0 writes: x26=2, then a write to x0 with wb_addr=0 → stays in RUN, `done`=0; a later x26=1 proceeds normally.
- Timeout: TIMEOUT_CYCLES=50, no flag → `done`=1, `timeout`=1, `fail`=1, `run_cycles`=50 after 50 cycles; flag and expiry in the same cycle → SETTLE, `timeout`=0.
- Reset mid-SETTLE: assert `rst` for 1 cycle → all outputs 0, state RUN; the subsequent pass sequence completes with the correct verdict.
